// File: rtl/ysyx_25030093_mem_resp_pkg.sv
// Shared types and constants for the simulation memory responder and its
// optional random-latency LFSR.
package ysyx_25030093_mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [7:0]  LFSR_SEED   = 8'hA5;
    // Fibonacci taps 8,6,5,4 expressed as a bit mask over state[7:0]
    localparam logic [7:0]  LFSR_TAPS   = 8'hB8;
    localparam logic [31:0] STORE_RDATA = 32'h0;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/ysyx_25030093_mem_resp_if.sv
// Request/response handshake bundle between the LSU requester and the
// memory responder.
interface ysyx_25030093_mem_resp_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;

    modport master (
        output req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/ysyx_25030093_lfsr8.sv
// 8-bit Fibonacci LFSR, free-running, reseeded on rst; supplies the
// random access latency of the memory responder.
module ysyx_25030093_lfsr8
    import ysyx_25030093_mem_resp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] state_o
);

    logic [7:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= LFSR_SEED;
        else     lfsr_q <= lfsr_next(lfsr_q);
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/ysyx_25030093_mem_resp.sv
// Simulation memory responder: one request at a time, fixed (or, with
// MEM_RAND_DELAY_EN defined, LFSR-random 0..7) latency, byte-masked stores.
module ysyx_25030093_mem_resp
    import ysyx_25030093_mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    ysyx_25030093_mem_resp_if.slave   bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            wen_q, wen_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      wmask_q, wmask_d;
    logic [31:0]     rdata_q;
    logic            access;
    logic [3:0]      load_cnt;

    logic [31:0]     mem [DEPTH];

    logic unused_addr;
    assign unused_addr = ^{bus.req_addr[1:0], bus.req_addr[31:AW+2]};

`ifdef MEM_RAND_DELAY_EN
    logic [7:0] lfsr;
    logic       unused_lfsr;

    ysyx_25030093_lfsr8 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .state_o (lfsr)
    );

    assign load_cnt    = {1'b0, lfsr[2:0]};
    assign unused_lfsr = ^lfsr[7:3];
`else
    assign load_cnt = 4'(LATENCY);
`endif

    // req_ready is masked by rst so nothing is accepted during reset
    assign bus.req_ready = (state_q == IDLE) && !rst;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && bus.req_ready) begin
                    idx_d   = bus.req_addr[AW+1:2];
                    wen_d   = bus.req_wen;
                    wdata_d = bus.req_wdata;
                    wmask_d = bus.req_wmask;
                    cnt_d   = load_cnt;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    access  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (access) rdata_q <= wen_q ? STORE_RDATA : mem[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        idx_q   <= idx_d;
        wen_q   <= wen_d;
        wdata_q <= wdata_d;
        wmask_q <= wmask_d;
    end

    // Memory is never reset; a reset landing on the access edge drops the store
    always_ff @(posedge clk) begin
        if (access && wen_q && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25030093_mem_resp.sv
// Bench for the memory responder: three instances (LATENCY 1, 0, 4) driven by
// directed and random transactions, checked every cycle against a
// transaction-level model (accept time + latency, word map keyed by index).
module tb_ysyx_25030093_mem_resp;

    localparam int NI = 3;

    function automatic int lat(int k);
        return (k == 0) ? 1 : (k == 1) ? 0 : 4;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst  [NI];
    logic        v    [NI];
    logic        wen  [NI];
    logic        rspr [NI];
    logic [31:0] addr [NI];
    logic [31:0] wd   [NI];
    logic [3:0]  wm   [NI];
    logic        rdy  [NI];
    logic        rv   [NI];
    logic [31:0] rd   [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned L = (g == 0) ? 1 : (g == 1) ? 0 : 4;
        ysyx_25030093_mem_resp_if bus ();
        assign bus.req_valid = v[g];
        assign bus.req_wen   = wen[g];
        assign bus.req_addr  = addr[g];
        assign bus.req_wdata = wd[g];
        assign bus.req_wmask = wm[g];
        assign bus.rsp_ready = rspr[g];
        assign rdy[g]        = bus.req_ready;
        assign rv[g]         = bus.rsp_valid;
        assign rd[g]         = bus.rsp_rdata;
        ysyx_25030093_mem_resp #(.DEPTH(1024), .LATENCY(L)) u_dut (
            .clk (clk),
            .rst (rst[g]),
            .bus (bus)
        );
    end

    // model state
    logic        busy      [NI];
    int unsigned acc_cyc   [NI];
    logic [31:0] exp_rd    [NI];
    logic        exp_known [NI];
    logic        rst_seen  [NI];
    logic [31:0] mem_m [int];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cyc %0d: got %h expected %h", name, k, cyc, act, exp);
        end
    endtask

    always @(posedge clk) for (int k = 0; k < NI; k++) rst_seen[k] <= rst[k];

    always @(negedge clk) begin : cmp
        logic ev, er;
        if (cyc > 0) begin
            for (int k = 0; k < NI; k++) begin
                er = !busy[k] && !rst[k];
                ev = busy[k] && (cyc >= acc_cyc[k] + lat(k) + 1);
                chk("req_ready", k, 32'(rdy[k]), 32'(er));
                chk("rsp_valid", k, 32'(rv[k]), 32'(ev));
                if (ev && exp_known[k])  chk("rsp_rdata", k, rd[k], exp_rd[k]);
                else if (rst_seen[k])    chk("rst_rdata", k, rd[k], 32'h0);
            end
        end
    end

    // Called at posedge+#1 with instance k idle. rsta>0: rst is high at edge
    // acc+rsta, which aborts the transaction.
    task automatic xact(int k, logic w, logic [31:0] a, logic [31:0] d, logic [3:0] m,
                        int hold, int rsta, logic chk_lit, logic [31:0] lit);
        int          key;
        logic [31:0] nw;
        key = k * 1024 + int'((a >> 2) & 32'h3FF);
        v[k] = 1'b1; wen[k] = w; addr[k] = a; wd[k] = d; wm[k] = m;
        @(posedge clk); #1;
        busy[k] = 1'b1;
        acc_cyc[k] = cyc;
        if (w) begin
            exp_rd[k] = 32'h0;
            exp_known[k] = 1'b1;
            if ((rsta < 0 || rsta > lat(k) + 1) && (mem_m.exists(key) || m == 4'hF)) begin
                nw = mem_m.exists(key) ? mem_m[key] : 32'h0;
                for (int i = 0; i < 4; i++) if (m[i]) nw[8*i +: 8] = d[8*i +: 8];
                mem_m[key] = nw;
            end
        end else begin
            exp_known[k] = mem_m.exists(key);
            exp_rd[k] = exp_known[k] ? mem_m[key] : 32'h0;
        end
        if (chk_lit) chk("model_lit", k, exp_rd[k], lit);
        for (int e = 1; e < 200; e++) begin
            v[k] = 1'($urandom_range(0, 1));
            wen[k] = 1'($urandom); addr[k] = $urandom; wd[k] = $urandom; wm[k] = 4'($urandom);
            if (rsta == e) rst[k] = 1'b1;
            if (e <= lat(k) + 1)                       rspr[k] = 1'($urandom_range(0, 1));
            else if (rsta < 0 && e == lat(k) + 2 + hold) rspr[k] = 1'b1;
            else                                       rspr[k] = 1'b0;
            @(posedge clk); #1;
            if (rsta == e || (rsta < 0 && e == lat(k) + 2 + hold)) begin
                rst[k] = 1'b0; rspr[k] = 1'b0; v[k] = 1'b0; busy[k] = 1'b0;
                break;
            end
        end
    endtask

    task automatic idle(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        int          k, hold, rsta, idx;
        logic        w;
        logic [31:0] a;
        logic [3:0]  m;
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1; v[i] = 1'b0; wen[i] = 1'b0; rspr[i] = 1'b0;
            addr[i] = '0; wd[i] = '0; wm[i] = '0;
            busy[i] = 1'b0; acc_cyc[i] = 0; exp_rd[i] = '0; exp_known[i] = 1'b0;
        end
        idle(3);
        for (int i = 0; i < NI; i++) rst[i] = 1'b0;
        idle(1);

        // LATENCY=1 instance
        xact(0, 1, 32'h10, 32'h12345678, 4'hF, 0, -1, 0, 0);
        xact(0, 0, 32'h10, 32'h0, 4'h0, 0, -1, 1, 32'h12345678);
        xact(0, 1, 32'h10, 32'hAABBCCDD, 4'b0101, 0, -1, 0, 0);
        xact(0, 0, 32'h10, 32'h0, 4'h0, 0, -1, 1, 32'h12BB56DD);
        xact(0, 0, 32'h10, 32'h0, 4'h0, 10, -1, 1, 32'h12BB56DD);
        xact(0, 1, 32'h10, 32'h55555555, 4'h0, 0, -1, 0, 0);
        xact(0, 0, 32'h13, 32'h0, 4'h0, 0, -1, 1, 32'h12BB56DD);
        xact(0, 0, 32'h10, 32'h0, 4'h0, 5, 4, 1, 32'h12BB56DD);
        idle(2);
        // LATENCY=0 instance, index wrap
        xact(1, 1, 32'h1000, 32'hCAFEF00D, 4'hF, 0, -1, 0, 0);
        xact(1, 0, 32'h0, 32'h0, 4'h0, 0, -1, 1, 32'hCAFEF00D);
        // LATENCY=4 instance, reset during WAIT drops the store
        xact(2, 1, 32'h20, 32'h11223344, 4'hF, 0, -1, 0, 0);
        xact(2, 1, 32'h20, 32'hFFFFFFFF, 4'hF, 0, 2, 0, 0);
        xact(2, 0, 32'h20, 32'h0, 4'h0, 0, -1, 1, 32'h11223344);
        idle(2);

        for (int n = 0; n < 300; n++) begin
            k    = $urandom_range(0, NI - 1);
            idx  = $urandom_range(0, 15);
            a    = ($urandom & 32'hFFFF_F000) | (32'(idx) << 2) | ($urandom & 32'h3);
            w    = 1'($urandom_range(0, 1));
            m    = mem_m.exists(k * 1024 + idx) ? 4'($urandom) : 4'hF;
            hold = $urandom_range(0, 3);
            rsta = -1;
            if ($urandom_range(0, 9) == 0) begin
                rsta = $urandom_range(1, lat(k) + 2 + hold);
                if (rsta == lat(k) + 1) rsta = lat(k) + 2;
            end
            xact(k, w, a, $urandom, m, hold, rsta, 0, 0);
            idle($urandom_range(0, 2));
        end
        idle(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
